// File: rtl/flash_erase_sequencer.sv
// Sector-erase sequencer for the SPI flash interface: WREN, sector erase, then RDSR polling.
// Optional low-sector write protection is enabled with `define FLASH_SEQ_PROTECT_EN.
module flash_erase_sequencer #(
    parameter logic [7:0]  ERASE_OPCODE   = 8'hD8,
    parameter int unsigned POLL_GAP       = 1024,
    parameter logic [15:0] MAX_POLLS      = 16'd60000,
    parameter int unsigned ACK_TIMEOUT    = 4096,
    parameter logic [7:0]  PROTECT_SECTOR = 8'd16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] erase_addr,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  error_code,
    output logic [7:0]  status_last,
    output logic [15:0] poll_count,
    output logic [8:0]  flash_wr_nBytes,
    output logic [8:0]  flash_rd_nBytes,
    output logic        flash_cmd_strobe,
    input  logic        flash_cmd_ack,
    output logic        wbuf_wr_en,
    output logic [6:0]  wbuf_wr_addr,
    output logic [31:0] wbuf_data,
    output logic        rbuf_rd_en,
    output logic [6:0]  rbuf_rd_addr,
    input  logic [31:0] rbuf_data
);

    typedef enum logic [3:0] {
        StIdle, StLdWren, StLdErase, StLdRdsr, StIssue, StRelease,
        StRdSr, StChkSr, StGap, StDone, StErr
    } state_e;

    typedef enum logic [1:0] {PhWren, PhErase, PhRdsr} phase_e;

    localparam int unsigned AckW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GapW = $clog2(POLL_GAP + 1);
    localparam logic [AckW-1:0] AckLast = AckW'(ACK_TIMEOUT - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(POLL_GAP - 1);

    state_e          state_q, state_d;
    phase_e          phase_q, phase_d;
    logic [23:0]     addr_q, addr_d;
    logic            busy_q, busy_d;
    logic            error_q, error_d;
    logic [1:0]      code_q, code_d;
    logic [7:0]      status_q, status_d;
    logic [15:0]     poll_q, poll_d;
    logic [8:0]      wr_nbytes_q, wr_nbytes_d;
    logic [8:0]      rd_nbytes_q, rd_nbytes_d;
    logic [AckW-1:0] ack_cnt_q, ack_cnt_d;
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
    logic            ack_meta_q, ack_s_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            phase_q     <= PhWren;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= '0;
            status_q    <= '0;
            poll_q      <= '0;
            wr_nbytes_q <= '0;
            rd_nbytes_q <= '0;
            ack_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            ack_meta_q  <= 1'b0;
            ack_s_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            error_q     <= error_d;
            code_q      <= code_d;
            status_q    <= status_d;
            poll_q      <= poll_d;
            wr_nbytes_q <= wr_nbytes_d;
            rd_nbytes_q <= rd_nbytes_d;
            ack_cnt_q   <= ack_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            ack_meta_q  <= flash_cmd_ack;
            ack_s_q     <= ack_meta_q;
        end
    end

    always_comb begin
        state_d          = state_q;
        phase_d          = phase_q;
        addr_d           = addr_q;
        busy_d           = busy_q;
        error_d          = error_q;
        code_d           = code_q;
        status_d         = status_q;
        poll_d           = poll_q;
        wr_nbytes_d      = wr_nbytes_q;
        rd_nbytes_d      = rd_nbytes_q;
        ack_cnt_d        = ack_cnt_q;
        gap_cnt_d        = gap_cnt_q;
        wbuf_wr_en       = 1'b0;
        wbuf_data        = '0;
        rbuf_rd_en       = 1'b0;
        flash_cmd_strobe = 1'b0;
        done             = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = erase_addr;
                    error_d = 1'b0;
                    code_d  = 2'd0;
                    poll_d  = '0;
                    busy_d  = 1'b1;
                    state_d = StLdWren;
`ifdef FLASH_SEQ_PROTECT_EN
                    // Sectors below PROTECT_SECTOR hold the golden image
                    if (erase_addr[23:16] < PROTECT_SECTOR) begin
                        code_d  = 2'd3;
                        state_d = StErr;
                    end
`endif
                end
            end
            StLdWren: begin
                wbuf_wr_en  = 1'b1;
                wbuf_data   = {8'h06, 24'h0};
                wr_nbytes_d = 9'd1;
                rd_nbytes_d = 9'd0;
                phase_d     = PhWren;
                ack_cnt_d   = '0;
                state_d     = StIssue;
            end
            StLdErase: begin
                wbuf_wr_en  = 1'b1;
                wbuf_data   = {ERASE_OPCODE, addr_q};
                wr_nbytes_d = 9'd4;
                rd_nbytes_d = 9'd0;
                phase_d     = PhErase;
                ack_cnt_d   = '0;
                state_d     = StIssue;
            end
            StLdRdsr: begin
                wbuf_wr_en  = 1'b1;
                wbuf_data   = {8'h05, 24'h0};
                wr_nbytes_d = 9'd1;
                rd_nbytes_d = 9'd1;
                phase_d     = PhRdsr;
                if (poll_q != 16'hFFFF) poll_d = poll_q + 16'd1;
                ack_cnt_d   = '0;
                state_d     = StIssue;
            end
            StIssue: begin
                flash_cmd_strobe = 1'b1;
                if (ack_s_q) begin
                    ack_cnt_d = '0;
                    state_d   = StRelease;
                end else if (ack_cnt_q == AckLast) begin
                    code_d  = 2'd1;
                    state_d = StErr;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (!ack_s_q) begin
                    unique case (phase_q)
                        PhWren:  state_d = StLdErase;
                        PhErase: state_d = StLdRdsr;
                        default: state_d = StRdSr;
                    endcase
                end else if (ack_cnt_q == AckLast) begin
                    code_d  = 2'd1;
                    state_d = StErr;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            StRdSr: begin
                rbuf_rd_en = 1'b1;
                state_d    = StChkSr;
            end
            StChkSr: begin
                status_d = rbuf_data[31:24];
                if (!rbuf_data[24]) begin
                    state_d = StDone;
                end else if (poll_q == MAX_POLLS) begin
                    code_d  = 2'd2;
                    state_d = StErr;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) state_d = StLdRdsr;
                else gap_cnt_d = gap_cnt_q + 1'b1;
            end
            StDone: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StErr: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Byte counts take their new value during the LD_* cycle and then hold
    assign flash_wr_nBytes = wr_nbytes_d;
    assign flash_rd_nBytes = rd_nbytes_d;
    assign wbuf_wr_addr    = 7'd0;
    assign rbuf_rd_addr    = 7'd0;
    assign busy            = busy_q;
    assign error           = error_q;
    assign error_code      = code_q;
    assign status_last     = status_q;
    assign poll_count      = poll_q;

    logic unused_rbuf;
    assign unused_rbuf = ^rbuf_data[23:0];
`ifndef FLASH_SEQ_PROTECT_EN
    logic unused_protect;
    assign unused_protect = ^PROTECT_SECTOR;
`endif

endmodule
